// File: rtl/dma_window_engine.sv
// DMA responder for the layer controller: fetches KxK convolution or 2x2 pooling
// windows from a single-port RAM and writes result feature maps back.
module dma_window_engine #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int K      = 5,
   parameter int SIZE_W = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       start_address,
   input  logic [SIZE_W-1:0]       image_size,
   input  logic                    pooling,
   input  logic                    write_to_mem,
   input  logic                    next_window,
   output logic [K*K*DATA_W-1:0]   window,
   output logic                    done,
   output logic                    last_window,
   output logic                    err,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic [DATA_W-1:0]       mem_rdata
);

   localparam int NWORD = K * K;
   localparam int CNT_W = $clog2(NWORD + 1);
   localparam int IDX_W = $clog2(NWORD);
   localparam int POS_W = $clog2(K + 1);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      READY,
      SHIFT,
      WRITE,
      DONE_WAIT,
      ERR
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0]       baseAddr_q, baseAddr_d;
   logic [SIZE_W-1:0]       imgSize_q, imgSize_d;
   logic                    pool_q, pool_d;
   logic [SIZE_W-1:0]       row_q, row_d;
   logic [SIZE_W-1:0]       col_q, col_d;
   logic [POS_W-1:0]        winRow_q, winRow_d;
   logic [POS_W-1:0]        winCol_q, winCol_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    capEn_q, capEn_d;
   logic [IDX_W-1:0]        capIdx_q, capIdx_d;
   logic [ADDR_W-1:0]       wrCnt_q, wrCnt_d;
   logic [K*K*DATA_W-1:0]   window_q, window_d;
   logic                    err_q, err_d;

   logic [SIZE_W-1:0]       maxPos;
   logic [SIZE_W-1:0]       stepSz;
   logic                    lastCol;
   logic                    lastRow;
   logic                    lastWin;
   logic [CNT_W-1:0]        burstLen;
   logic                    inBurst;
   logic                    issue;
   logic                    burstEnd;
   logic                    wrFire;
   logic [ADDR_W-1:0]       wrTotal;
   logic                    wrLast;
   logic                    cmdIllegal;
   logic                    accept;
   logic                    advance;
   logic [POS_W-1:0]        jMax;
   logic [ADDR_W-1:0]       rdRow;
   logic [ADDR_W-1:0]       rdCol;
   logic [ADDR_W-1:0]       rdAddr;

   // Pooling positions run over even offsets only, so an odd edge drops its last row/column.
   assign maxPos   = pool_q ? ({imgSize_q[SIZE_W-1:1], 1'b0} - SIZE_W'(2))
                            : (imgSize_q - SIZE_W'(K));
   assign stepSz   = pool_q ? SIZE_W'(2) : SIZE_W'(1);
   assign lastCol  = (col_q == maxPos);
   assign lastRow  = (row_q == maxPos);
   assign lastWin  = lastCol && lastRow;
   assign burstLen = (state_q == SHIFT) ? CNT_W'(K) : (pool_q ? CNT_W'(4) : CNT_W'(NWORD));
   assign inBurst  = (state_q == FILL) || (state_q == SHIFT);
   assign issue    = inBurst && (cnt_q < burstLen);
   assign burstEnd = inBurst && (cnt_q == burstLen);
   assign wrFire   = (state_q == WRITE) && wr_valid;
   assign wrTotal  = ADDR_W'(imgSize_q) * ADDR_W'(imgSize_q) - ADDR_W'(1);
   assign wrLast   = (wrCnt_q == wrTotal);
   assign accept   = (state_q == IDLE) && start;
   assign advance  = (state_q == READY) && start && next_window && !lastWin;
   assign jMax     = pool_q ? POS_W'(1) : POS_W'(K - 1);

   assign cmdIllegal = (image_size == '0) ||
                       (!write_to_mem && (pooling ? (image_size < SIZE_W'(2))
                                                  : (image_size < SIZE_W'(K))));

   assign rdRow  = ADDR_W'(row_q) + ADDR_W'(winRow_q);
   assign rdCol  = ADDR_W'(col_q) + ADDR_W'(winCol_q);
   assign rdAddr = baseAddr_q + rdRow * ADDR_W'(imgSize_q) + rdCol;

   assign window = window_q;
   assign err    = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cmdIllegal) begin
                  state_d = ERR;
               end else if (write_to_mem) begin
                  state_d = WRITE;
               end else begin
                  state_d = FILL;
               end
            end
         end
         FILL, SHIFT: begin
            if (burstEnd) begin
               state_d = READY;
            end
         end
         READY: begin
            if (!start) begin
               state_d = IDLE;
            end else if (next_window) begin
               if (lastWin) begin
                  state_d = DONE_WAIT;
               end else if (pool_q || lastCol) begin
                  state_d = FILL;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         WRITE: begin
            if (wrFire && wrLast) begin
               state_d = DONE_WAIT;
            end
         end
         DONE_WAIT, ERR: begin
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done        = 1'b0;
      last_window = 1'b0;
      wr_ready    = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (state_q)
         FILL, SHIFT: begin
            if (issue) begin
               mem_en   = 1'b1;
               mem_addr = rdAddr;
            end
         end
         READY: begin
            done        = 1'b1;
            last_window = lastWin;
         end
         WRITE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               mem_en    = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = baseAddr_q + wrCnt_q;
               mem_wdata = wr_data;
            end
         end
         DONE_WAIT, ERR: done = 1'b1;
         default: ;
      endcase
   end

   // Reads are captured one cycle after issue; capIdx_q remembers where the word lands.
   always_comb begin
      baseAddr_d = baseAddr_q;
      imgSize_d  = imgSize_q;
      pool_d     = pool_q;
      row_d      = row_q;
      col_d      = col_q;
      winRow_d   = winRow_q;
      winCol_d   = winCol_q;
      cnt_d      = cnt_q;
      capEn_d    = 1'b0;
      capIdx_d   = capIdx_q;
      wrCnt_d    = wrCnt_q;
      window_d   = window_q;
      err_d      = err_q;

      if (accept) begin
         baseAddr_d = start_address;
         imgSize_d  = image_size;
         pool_d     = pooling;
         row_d      = '0;
         col_d      = '0;
         winRow_d   = '0;
         winCol_d   = '0;
         cnt_d      = '0;
         wrCnt_d    = '0;
         err_d      = cmdIllegal;
      end

      if (issue) begin
         cnt_d    = cnt_q + CNT_W'(1);
         capEn_d  = 1'b1;
         capIdx_d = IDX_W'(int'(winRow_q) * K + int'(winCol_q));
         if (state_q == SHIFT) begin
            winRow_d = winRow_q + POS_W'(1);
         end else if (winCol_q == jMax) begin
            winCol_d = '0;
            winRow_d = winRow_q + POS_W'(1);
         end else begin
            winCol_d = winCol_q + POS_W'(1);
         end
      end

      if ((state_q == FILL) && (cnt_q == '0)) begin
         window_d = '0;
      end

      if (capEn_q) begin
         window_d[int'(capIdx_q) * DATA_W +: DATA_W] = mem_rdata;
      end

      if (burstEnd) begin
         cnt_d    = '0;
         winRow_d = '0;
         winCol_d = '0;
      end

      // A same-row conv step keeps K-1 columns and refetches only the rightmost one.
      if (advance) begin
         if (lastCol) begin
            col_d = '0;
            row_d = row_q + stepSz;
         end else begin
            col_d = col_q + stepSz;
         end
         if (!pool_q && !lastCol) begin
            for (int rr = 0; rr < K; rr++) begin
               for (int cc = 0; cc < K - 1; cc++) begin
                  window_d[(rr * K + cc) * DATA_W +: DATA_W] =
                     window_q[(rr * K + cc + 1) * DATA_W +: DATA_W];
               end
            end
            winCol_d = POS_W'(K - 1);
         end
      end

      if (wrFire) begin
         wrCnt_d = wrCnt_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baseAddr_q <= '0;
         imgSize_q  <= '0;
         pool_q     <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         winRow_q   <= '0;
         winCol_q   <= '0;
         cnt_q      <= '0;
         capEn_q    <= 1'b0;
         capIdx_q   <= '0;
         wrCnt_q    <= '0;
         window_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         baseAddr_q <= baseAddr_d;
         imgSize_q  <= imgSize_d;
         pool_q     <= pool_d;
         row_q      <= row_d;
         col_q      <= col_d;
         winRow_q   <= winRow_d;
         winCol_q   <= winCol_d;
         cnt_q      <= cnt_d;
         capEn_q    <= capEn_d;
         capIdx_q   <= capIdx_d;
         wrCnt_q    <= wrCnt_d;
         window_q   <= window_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_dma_window_engine.sv
// Scoreboard bench for dma_window_engine: a RAM model plus a window reference model
// feed expected responses to a monitor that checks every rising done.
module tb_dma_window_engine;

   localparam int DW   = 16;
   localparam int AW   = 16;
   localparam int K    = 5;
   localparam int SW   = 6;
   localparam int WINW = K * K * DW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [AW-1:0]   start_address = '0;
   logic [SW-1:0]   image_size = '0;
   logic            pooling = 1'b0;
   logic            write_to_mem = 1'b0;
   logic            next_window = 1'b0;
   logic [WINW-1:0] window;
   logic            done;
   logic            last_window;
   logic            err;
   logic [DW-1:0]   wr_data = '0;
   logic            wr_valid = 1'b0;
   logic            wr_ready;
   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   typedef struct {
      logic [WINW-1:0] win;
      logic            last;
      logic            err;
      bit              chkWin;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   checks = 0;
   int   errors = 0;
   logic donePrev = 1'b0;

   logic          tbWe = 1'b0;
   logic [AW-1:0] tbAddr = '0;
   logic [DW-1:0] tbData = '0;
   logic [DW-1:0] ram [0:65535];
   int            memWrites = 0;
   int            memEnCount = 0;

   dma_window_engine dut (
      .clk(clk), .rst(rst), .start(start), .start_address(start_address),
      .image_size(image_size), .pooling(pooling), .write_to_mem(write_to_mem),
      .next_window(next_window), .window(window), .done(done),
      .last_window(last_window), .err(err), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tbWe) begin
         ram[tbAddr] <= tbData;
      end else if (mem_en && mem_we) begin
         ram[mem_addr] <= mem_wdata;
         memWrites <= memWrites + 1;
      end
      if (mem_en) memEnCount <= memEnCount + 1;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [WINW-1:0] act, input logic [WINW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         donePrev = 1'b0;
      end else begin
         if (done && !donePrev) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got done=1, required no response pending");
            end else begin
               monE = expQ.pop_front();
               checkOutput("err_on_done", err, monE.err);
               if (monE.chkWin) begin
                  checkOutput("window", window, monE.win);
                  checkOutput("last_window", last_window, monE.last);
               end
            end
         end
         donePrev = done;
      end
   end

   function automatic logic [WINW-1:0] refWindow(input logic [15:0] base, input int w,
                                                 input bit pool, input int r, input int c);
      logic [WINW-1:0] v;
      logic [15:0]     a;
      int              n;
      v = '0;
      n = pool ? 2 : K;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            a = 16'(int'(base) + (r + i) * w + c + j);
            v[(i * K + j) * DW +: DW] = ram[a];
         end
      end
      return v;
   endfunction

   task automatic loadWord(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      tbWe = 1'b1;
      tbAddr = a;
      tbData = d;
   endtask

   task automatic loadDone();
      @(negedge clk);
      tbWe = 1'b0;
   endtask

   task automatic waitDone(output int lat);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         next_window = 1'b0;
      end while (!done && n < 400);
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got done=0 after %0d cycles, required done=1", n);
      end
      lat = n - 1;
   endtask

   task automatic applyStimulus(input logic [15:0] base, input int w, input bit pool,
                                input bit randData, input string tag);
      int maxp, stp, lat, expLat;
      int rs[$];
      int cs[$];
      for (int k = 0; k < w * w; k++) loadWord(16'(int'(base) + k), randData ? 16'($urandom) : 16'(k));
      loadDone();
      stp  = pool ? 2 : 1;
      maxp = pool ? (w / 2) * 2 - 2 : w - K;
      for (int r = 0; r <= maxp; r += stp)
         for (int c = 0; c <= maxp; c += stp) begin
            rs.push_back(r);
            cs.push_back(c);
         end
      for (int i = 0; i < rs.size(); i++)
         expQ.push_back('{refWindow(base, w, pool, rs[i], cs[i]), (i == rs.size() - 1), 1'b0, 1'b1});
      start = 1'b1;
      start_address = base;
      image_size = SW'(w);
      pooling = pool;
      write_to_mem = 1'b0;
      waitDone(lat);
      checkOutput({tag, " fill_latency"}, lat, pool ? 5 : K * K + 1);
      for (int i = 1; i < rs.size(); i++) begin
         next_window = 1'b1;
         waitDone(lat);
         expLat = (!pool && cs[i] != 0) ? K + 1 : (pool ? 5 : K * K + 1);
         checkOutput({tag, " step_latency"}, lat, expLat);
      end
      next_window = 1'b1;
      @(posedge clk);
      @(negedge clk);
      next_window = 1'b0;
      checkOutput({tag, " done_hold_after_last"}, done, 1);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " idle_after_release"}, done, 0);
   endtask

   task automatic applyWriteStimulus(input logic [15:0] base, input int w, input bit usePattern);
      bit          pat [5] = '{1, 1, 1, 1, 1};
      logic [15:0] ea[$];
      logic [15:0] ed[$];
      int          k, cyc;
      bit          v;
      logic [15:0] d;
      pat[1] = 1'b0;
      k = 0;
      cyc = 0;
      expQ.push_back('{'0, 1'b0, 1'b0, 1'b0});
      start = 1'b1;
      write_to_mem = 1'b1;
      start_address = base;
      image_size = SW'(w);
      pooling = 1'b0;
      @(posedge clk);
      while (k < w * w && cyc < 500) begin
         @(negedge clk);
         checkOutput("wr_ready_in_write", wr_ready, 1);
         v = (usePattern && cyc < 5) ? pat[cyc] : 1'($urandom_range(0, 1));
         d = 16'($urandom);
         wr_valid = v;
         wr_data = d;
         @(posedge clk);
         if (v) begin
            ea.push_back(16'(int'(base) + k));
            ed.push_back(d);
            k++;
         end
         cyc++;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      checkOutput("done_after_last_write", done, 1);
      for (int i = 0; i < ea.size(); i++) checkOutput("ram_writeback", ram[ea[i]], ed[i]);
      repeat (3) @(negedge clk);
      checkOutput("done_held_while_start", done, 1);
      start = 1'b0;
      write_to_mem = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("write_idle_after_release", done, 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no completion, required end before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int memBefore;
      int wrBefore;
      int mode;
      int w;
      logic [15:0] base;

      repeat (3) @(negedge clk);
      checkOutput("reset_window", window, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_last", last_window, 0);
      checkOutput("reset_wr_ready", wr_ready, 0);
      checkOutput("reset_mem_en", mem_en, 0);
      checkOutput("reset_mem_addr", mem_addr, 0);
      rst = 1'b0;

      applyStimulus(16'd100, 5, 1'b0, 1'b0, "filter");
      applyStimulus(16'd0, 7, 1'b0, 1'b0, "conv7");
      applyStimulus(16'd0, 4, 1'b1, 1'b0, "pool4");
      applyStimulus(16'd500, 5, 1'b1, 1'b1, "pool5_odd");
      applyWriteStimulus(16'd1000, 2, 1'b1);

      memBefore = memEnCount;
      expQ.push_back('{'0, 1'b0, 1'b1, 1'b0});
      start = 1'b1;
      start_address = 16'd300;
      image_size = SW'(3);
      pooling = 1'b0;
      write_to_mem = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("illegal_err", err, 1);
      checkOutput("illegal_done", done, 1);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("illegal_idle_done", done, 0);
      checkOutput("illegal_err_sticky", err, 1);
      checkOutput("illegal_no_mem_en", memEnCount - memBefore, 0);

      applyStimulus(16'd3000, 6, 1'b0, 1'b1, "conv6_after_err");

      loadWord(16'd2000, 16'h1111);
      loadWord(16'd2001, 16'h2222);
      loadWord(16'd2002, 16'h3333);
      loadWord(16'd2003, 16'h4444);
      loadDone();
      wrBefore = memWrites;
      start = 1'b1;
      write_to_mem = 1'b1;
      start_address = 16'd2000;
      image_size = SW'(2);
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data = 16'hA0A0;
      @(posedge clk);
      @(negedge clk);
      wr_data = 16'hA1A1;
      @(posedge clk);
      @(negedge clk);
      wr_data = 16'hBBBB;
      rst = 1'b1;
      #1;
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_wr_ready", wr_ready, 0);
      checkOutput("rst_done", done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      wr_valid = 1'b0;
      write_to_mem = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ram0", ram[2000], 16'hA0A0);
      checkOutput("rst_ram1", ram[2001], 16'hA1A1);
      checkOutput("rst_ram2", ram[2002], 16'h3333);
      checkOutput("rst_ram3", ram[2003], 16'h4444);
      checkOutput("rst_write_count", memWrites - wrBefore, 2);

      applyStimulus(16'hFFF0, 6, 1'b0, 1'b1, "conv_wrap");

      for (int t = 0; t < 8; t++) begin
         mode = $urandom_range(0, 2);
         base = 16'($urandom);
         if (mode == 0) begin
            w = $urandom_range(5, 10);
            applyStimulus(base, w, 1'b0, 1'b1, "rand_conv");
         end else if (mode == 1) begin
            w = $urandom_range(2, 10);
            applyStimulus(base, w, 1'b1, 1'b1, "rand_pool");
         end else begin
            w = $urandom_range(1, 5);
            applyWriteStimulus(base, w, 1'b0);
         end
      end

      repeat (2) @(negedge clk);
      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
